vga_mode_sequencer: RTL
=======================

# vga_mode_sequencer

Controller that owns the `decode` pattern-select input of the 640x480 VGA timing/colour generator. It accepts mode-change requests from a valid/ready select port and a "next mode" pulse, and arbitrates between them. Accepted changes are committed only at a frame boundary (vsync falling edge), so a frame is never drawn in two modes. It sits between the board input logic and `vga640x480`, in the `pclk` domain.

## Interface
- `NUM_MODES`, 8: number of legal modes; 2..8; `decode` wraps modulo `NUM_MODES`.
- `RESET_MODE`, 0: value of `decode` after reset; must be < `NUM_MODES`.
- `AUTO_FRAMES`, 60: frames per step in auto-cycle; 1..65535; used only when `VGA_MODE_AUTOCYCLE_EN` is defined.
- `pclk`  in  1  pixel clock; same clock as `vga640x480`.
- `rst`  in  1  reset; one clock; synchronous and active-high.
- `vsync`  in  1  active-low vsync from `vga640x480`; synchronous to `pclk`, no synchroniser.
- `sel_valid`  in  1  direct-select request.
- `sel_code`  in  3  requested mode.
- `sel_ready`  out  1  select port can accept.
- `btn_next`  in  1  single-cycle pulse; request `decode+1`, wrapping.
- `auto_en`  in  1  auto-cycle enable; ignored when the macro is absent.
- `decode`  out  3  registered mode select to `vga640x480`.
- `commit`  out  1  one-cycle pulse in the cycle `decode` takes a new value.
- `err`  out  1  one-cycle pulse when an out-of-range `sel_code` is accepted.

## Operation
- Frame boundary `fb`:
  - `vsync_q` is `vsync` registered.
  - `fb = vsync_q & ~vsync`.
- States:
  - IDLE: no change pending.
  - PENDING: holds `target` and waits for `fb`.
- IDLE:
  - `sel_ready = 1`.
  - Handshake when `sel_valid & sel_ready`.
  - If `sel_code < NUM_MODES`: `target <= sel_code`, go to PENDING.
  - Otherwise: `err` pulses and the state stays IDLE.
  - Else if `btn_next`: `target <= (decode+1) mod NUM_MODES`, go to PENDING.
- Simultaneous `sel_valid` and `btn_next` in IDLE: select wins and `btn_next` is dropped.
- PENDING:
  - `sel_ready = 0`.
  - `btn_next` is dropped.
  - On `fb`: `decode <= target`, `commit <= 1`, go to IDLE.
  - A request accepted in a cycle where `fb = 1` commits at the next `fb`, never the same one.
- `target == decode` still commits, and `commit` still pulses.
- Reset while `rst` is high:
  - state = IDLE, `decode = RESET_MODE`.
  - `commit = 0`, `err = 0`, `vsync_q = 1`.
  - `sel_ready = 0`.
  - Any pending request is discarded.

## Timing
- `decode`, `commit` and `err` are registered outputs. `sel_ready` is combinational from state and `rst`.
- Commit latency: `decode` changes at the end of the `pclk` cycle in which `fb = 1`. `commit` is high for exactly the following cycle.
- Worst-case request-to-display latency is one frame plus one cycle.
- `err` is high for the cycle after the handshake.

## Configuration
- `VGA_MODE_AUTOCYCLE_EN` defined:
  - A 16-bit frame counter increments on each `fb` in IDLE while `auto_en = 1`.
  - When the counter equals `AUTO_FRAMES-1` on an `fb`: `decode <= (decode+1) mod NUM_MODES`, `commit` pulses, counter clears.
  - The counter clears on any manual commit, on `auto_en = 0`, and on reset.
  - A PENDING request takes priority: the counter does not advance in PENDING.
- Macro undefined:
  - No counter is built and `auto_en` is unused.
  - `decode` changes only through requests.

## Structure
- Package `vga_mode_pkg`:
  - `MODE_W = 3`.
  - State enum `{ST_IDLE, ST_PENDING}`.
  - Default `RESET_MODE` constant.
- Sub-module `vga_frame_tick`: registers `vsync` and emits `fb`; reset value `vsync_q = 1`.
- Request arbitration, the FSM and the optional auto counter stay in the top module.

## Test plan
- Reset with `RESET_MODE = 2`:
  - `decode = 2`, `commit = 0`, `sel_ready = 0` while `rst = 1`.
  - `sel_ready = 1` in the first cycle after.
- `sel_code = 5` accepted mid-frame:
  - `sel_ready` drops next cycle.
  - `decode` stays at its old value until vsync falls.
  - Then `decode = 5` one cycle after the fall, with a single `commit` pulse.
- `btn_next` at `decode = 7`, `NUM_MODES = 8`: commits to `decode = 0` at the next `fb`.
- `sel_valid` (code 3) and `btn_next` in the same IDLE cycle: only 3 commits; a second `btn_next` in PENDING is ignored.
- `sel_code = 6` with `NUM_MODES = 6`: `err` pulses once; no PENDING, no commit, `decode` unchanged.
- With the macro, `AUTO_FRAMES = 3`, `auto_en = 1`:
  - `decode` increments on every third vsync fall.
  - A manual commit restarts the three-frame count.
  - Reset asserted during PENDING drops the request.

Source files
------------

// File: rtl/vga_mode_pkg.sv
// Shared types and constants for the VGA mode sequencer.
package vga_mode_pkg;

    localparam int unsigned MODE_W = 3;
    localparam int unsigned DEFAULT_RESET_MODE = 0;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } state_t;

    // Increment with wrap; 'last' is NUM_MODES-1.
    function automatic logic [MODE_W-1:0] mode_inc(input logic [MODE_W-1:0] m,
                                                   input logic [MODE_W-1:0] last);
        return (m >= last) ? '0 : m + 1'b1;
    endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// Registers vsync and flags the frame boundary (vsync falling edge).
module vga_frame_tick (
    input  logic pclk,
    input  logic rst,
    input  logic vsync,
    output logic fb
);

    logic vsync_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            vsync_q <= 1'b1;
        end else begin
            vsync_q <= vsync;
        end
    end

    assign fb = vsync_q & ~vsync;

endmodule

// File: rtl/vga_mode_sequencer.sv
// Arbitrates mode-change requests and commits them to decode on frame boundaries.
// Optional auto-cycling is built only when VGA_MODE_AUTOCYCLE_EN is defined.
module vga_mode_sequencer
    import vga_mode_pkg::*;
#(
    parameter int unsigned NUM_MODES   = 8,
    parameter int unsigned RESET_MODE  = DEFAULT_RESET_MODE,
    parameter int unsigned AUTO_FRAMES = 60
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              sel_valid,
    input  logic [MODE_W-1:0] sel_code,
    output logic              sel_ready,
    input  logic              btn_next,
    input  logic              auto_en,
    output logic [MODE_W-1:0] decode,
    output logic              commit,
    output logic              err
);

    localparam logic [MODE_W:0]   NUM_M     = (MODE_W+1)'(NUM_MODES);
    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0] RST_MODE  = MODE_W'(RESET_MODE);
    localparam logic [15:0]       AUTO_LAST = 16'(AUTO_FRAMES - 1);

    state_t            state;
    logic [MODE_W-1:0] target;
    logic              fb;

    vga_frame_tick u_tick (
        .pclk  (pclk),
        .rst   (rst),
        .vsync (vsync),
        .fb    (fb)
    );

    assign sel_ready = (state == ST_IDLE) && !rst;

`ifdef VGA_MODE_AUTOCYCLE_EN
    logic [15:0] auto_cnt;
`else
    logic unused_cfg;
    assign unused_cfg = ^{auto_en, AUTO_LAST};
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            state  <= ST_IDLE;
            target <= RST_MODE;
            decode <= RST_MODE;
            commit <= 1'b0;
            err    <= 1'b0;
`ifdef VGA_MODE_AUTOCYCLE_EN
            auto_cnt <= '0;
`endif
        end else begin
            commit <= 1'b0;
            err    <= 1'b0;
`ifdef VGA_MODE_AUTOCYCLE_EN
            if (!auto_en) auto_cnt <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    // Select outranks btn_next; a request accepted on an fb
                    // cycle waits for the following fb.
                    if (sel_valid) begin
                        if ({1'b0, sel_code} < NUM_M) begin
                            target <= sel_code;
                            state  <= ST_PENDING;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (btn_next) begin
                        target <= mode_inc(decode, LAST_MODE);
                        state  <= ST_PENDING;
                    end
`ifdef VGA_MODE_AUTOCYCLE_EN
                    else if (auto_en && fb) begin
                        if (auto_cnt == AUTO_LAST) begin
                            decode   <= mode_inc(decode, LAST_MODE);
                            commit   <= 1'b1;
                            auto_cnt <= '0;
                        end else begin
                            auto_cnt <= auto_cnt + 16'd1;
                        end
                    end
`endif
                end
                ST_PENDING: begin
                    if (fb) begin
                        decode <= target;
                        commit <= 1'b1;
                        state  <= ST_IDLE;
`ifdef VGA_MODE_AUTOCYCLE_EN
                        auto_cnt <= '0;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
